user_obi_copy_mgr: RTL and testbench

User-domain word-copy engine: the initiator counterpart to the user subordinate bus. Software programs source, destination and length through an OBI subordinate register port on the user demux. The block then drives the user manager port, reading each 32-bit word and writing it back out, one transaction at a time, and raises an interrupt when done.

---
 rtl/user_obi_copy_mgr.sv | 261 ++++++++++++++++++++++++++
 tb/tb_user_obi_copy_mgr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_obi_copy_mgr.sv
// User-domain word-copy engine: OBI register port for SRC/DST/LEN/CTRL, OBI manager
// port that reads each word and writes it back out, one transaction at a time.

package croc_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};
    localparam obi_cfg_t MgrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        mgr_obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;
endpackage

module user_obi_copy_mgr #(
    parameter croc_pkg::obi_cfg_t SbrObiCfg = croc_pkg::SbrObiCfg,
    parameter croc_pkg::obi_cfg_t MgrObiCfg = croc_pkg::MgrObiCfg,
    parameter type sbr_obi_req_t = croc_pkg::sbr_obi_req_t,
    parameter type sbr_obi_rsp_t = croc_pkg::sbr_obi_rsp_t,
    parameter type mgr_obi_req_t = croc_pkg::mgr_obi_req_t,
    parameter type mgr_obi_rsp_t = croc_pkg::mgr_obi_rsp_t,
    parameter int unsigned LenWidth = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  sbr_obi_req_t obi_req_i,
    output sbr_obi_rsp_t obi_rsp_o,
    output mgr_obi_req_t obi_req_o,
    input  mgr_obi_rsp_t obi_rsp_i,
    output logic         irq_o
);
    localparam int unsigned SbrDw  = SbrObiCfg.DataWidth;
    localparam int unsigned SbrIdw = SbrObiCfg.IdWidth;
    localparam int unsigned MgrAw  = MgrObiCfg.AddrWidth;
    localparam int unsigned MgrDw  = MgrObiCfg.DataWidth;
    localparam int unsigned MgrIdw = MgrObiCfg.IdWidth;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

    state_e              state_q;
    logic [MgrAw-1:0]    src_q, dst_q, cur_src_q, cur_dst_q, maddr_q;
    logic [LenWidth-1:0] len_q, rem_q;
    logic [MgrDw-1:0]    buf_q;
    logic                mreq_q, mwe_q;
    logic                irq_en_q, done_q, err_q;
    logic                rvalid_q;
    logic [SbrIdw-1:0]   rid_q;
    logic [SbrDw-1:0]    rdata_q, rdata_d;

    logic       busy, sbr_wr, wr_ctrl, start, clr;
    logic [1:0] sel;

    assign busy    = (state_q != IDLE);
    assign sel     = obi_req_i.a.addr[3:2];
    assign sbr_wr  = obi_req_i.req & obi_req_i.a.we;
    assign wr_ctrl = sbr_wr & (sel == 2'd3);
    assign start   = wr_ctrl & obi_req_i.a.wdata[0];
    // start wins over clear when both are written together
    assign clr     = wr_ctrl & obi_req_i.a.wdata[2] & ~obi_req_i.a.wdata[0];

    always_comb begin
        rdata_d = '0;
        case (sel)
            2'd0: rdata_d = SbrDw'(src_q);
            2'd1: rdata_d = SbrDw'(dst_q);
            2'd2: rdata_d = SbrDw'(len_q);
            default: rdata_d = SbrDw'({irq_en_q, err_q, done_q, busy});
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            buf_q     <= '0;
            maddr_q   <= '0;
            mreq_q    <= 1'b0;
            mwe_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                rid_q   <= obi_req_i.a.aid;
                rdata_q <= rdata_d;
            end

            if (sbr_wr && !busy) begin
                case (sel)
                    2'd0: src_q <= {obi_req_i.a.wdata[MgrAw-1:2], 2'b00};
                    2'd1: dst_q <= {obi_req_i.a.wdata[MgrAw-1:2], 2'b00};
                    2'd2: len_q <= obi_req_i.a.wdata[LenWidth-1:0];
                    default: ;
                endcase
            end
            if (wr_ctrl) irq_en_q <= obi_req_i.a.wdata[1];
            if (clr) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end

            // Request fields only change on state transitions, so they hold until gnt.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        cur_src_q <= src_q;
                        cur_dst_q <= dst_q;
                        rem_q     <= len_q;
                        if (len_q == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RD_REQ;
                            mreq_q  <= 1'b1;
                            mwe_q   <= 1'b0;
                            maddr_q <= src_q;
                            buf_q   <= '0;
                        end
                    end
                end
                RD_REQ: begin
                    if (obi_rsp_i.gnt) begin
                        mreq_q  <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (obi_rsp_i.rvalid) begin
                        if (obi_rsp_i.r.err) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            buf_q   <= obi_rsp_i.r.rdata;
                            mreq_q  <= 1'b1;
                            mwe_q   <= 1'b1;
                            maddr_q <= cur_dst_q;
                            state_q <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (obi_rsp_i.gnt) begin
                        mreq_q  <= 1'b0;
                        state_q <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (obi_rsp_i.rvalid) begin
                        if (obi_rsp_i.r.err) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cur_src_q <= cur_src_q + MgrAw'(4);
                            cur_dst_q <= cur_dst_q + MgrAw'(4);
                            rem_q     <= rem_q - LenWidth'(1);
                            if (rem_q == LenWidth'(1)) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                mreq_q  <= 1'b1;
                                mwe_q   <= 1'b0;
                                maddr_q <= cur_src_q + MgrAw'(4);
                                buf_q   <= '0;
                                state_q <= RD_REQ;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        obi_req_o         = '0;
        obi_req_o.req     = mreq_q;
        obi_req_o.a.addr  = maddr_q;
        obi_req_o.a.we    = mwe_q;
        obi_req_o.a.be    = {4{mreq_q}};
        obi_req_o.a.wdata = buf_q;
        obi_req_o.a.aid   = {MgrIdw{1'b0}};
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = 1'b0;
    end

    assign irq_o = done_q & irq_en_q;

    logic unused_bits;
    assign unused_bits = ^{obi_req_i.a.be, obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0],
                           obi_rsp_i.r.rid};

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Randomized bench for user_obi_copy_mgr: register-port driver, random-latency memory
// responder, and a transaction-list reference model of the copy.

module tb_user_obi_copy_mgr;
    import croc_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    sbr_obi_req_t sreq;
    sbr_obi_rsp_t srsp;
    mgr_obi_req_t mreq;
    mgr_obi_rsp_t mrsp;
    logic irq;

    user_obi_copy_mgr dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .obi_req_i(sreq), .obi_rsp_o(srsp),
        .obi_req_o(mreq), .obi_rsp_i(mrsp),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] seed;
    int          max_dly = 0, err_rd = -1, rd_cnt = 0, first_req_cyc = -1, irq_cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // Memory responder: random grant latency, rvalid the cycle after grant.
    initial begin : responder
        logic        in_req, pend, pend_err;
        logic [31:0] pend_data;
        int          dly;
        txn_t        snap;
        in_req = 0; pend = 0; pend_err = 0; pend_data = '0; dly = 0;
        mrsp = '0;
        forever begin
            @(negedge clk);
            mrsp = '0;
            if (!rst_ni) begin
                pend = 0;
                in_req = 0;
                continue;
            end
            if (pend) begin
                mrsp.rvalid = 1'b1;
                mrsp.r.rdata = pend_data;
                mrsp.r.err = pend_err;
                pend = 0;
            end
            if (mreq.req) begin
                if (!in_req) begin
                    in_req = 1;
                    dly = $urandom_range(max_dly, 0);
                    snap.addr = mreq.a.addr; snap.we = mreq.a.we; snap.wdata = mreq.a.wdata;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                end else begin
                    chk("stable_addr", mreq.a.addr, snap.addr);
                    chk("stable_we", 32'(mreq.a.we), 32'(snap.we));
                    chk("stable_wdata", mreq.a.wdata, snap.wdata);
                end
                if (dly == 0) begin
                    mrsp.gnt = 1'b1;
                    in_req = 0;
                    chk("mgr_be", 32'(mreq.a.be), 32'hF);
                    log_q.push_back(snap);
                    pend = 1;
                    if (!snap.we) begin
                        pend_data = mem_word(snap.addr);
                        pend_err = (rd_cnt == err_rd);
                        rd_cnt++;
                    end else begin
                        pend_data = '0;
                        pend_err = 0;
                    end
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        logic [3:0] id;
        id = 4'($urandom);
        @(negedge clk);
        sreq.req = 1'b1; sreq.a.we = 1'b1; sreq.a.addr = a; sreq.a.wdata = d;
        sreq.a.be = 4'($urandom); sreq.a.aid = id;
        #1 chk("wr_gnt", 32'(srsp.gnt), 1);
        @(negedge clk);
        sreq.req = 1'b0;
        chk("wr_rvalid", 32'(srsp.rvalid), 1);
        chk("wr_rid", 32'(srsp.r.rid), 32'(id));
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        logic [3:0] id;
        id = 4'($urandom);
        @(negedge clk);
        sreq.req = 1'b1; sreq.a.we = 1'b0; sreq.a.addr = a; sreq.a.wdata = $urandom;
        sreq.a.be = 4'($urandom); sreq.a.aid = id;
        #1 chk("rd_gnt", 32'(srsp.gnt), 1);
        @(negedge clk);
        sreq.req = 1'b0;
        chk("rd_rvalid", 32'(srsp.rvalid), 1);
        chk("rd_rid", 32'(srsp.r.rid), 32'(id));
        d = srsp.r.rdata;
        @(negedge clk);
        chk("rd_rvalid_drop", 32'(srsp.rvalid), 0);
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                              input int dly, input int erd);
        max_dly = dly; err_rd = erd; rd_cnt = 0;
        log_q.delete();
        seed = $urandom;
        reg_write(32'h0, src);
        reg_write(32'h4, dst);
        reg_write(32'h8, 32'(len));
        first_req_cyc = -1;
        reg_write(32'hC, 32'h3);
    endtask

    // Reference: word i is read from src+4i and written to dst+4i; an errored read ends it.
    task automatic finish_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input int erd);
        int n;
        for (int k = 0; k < 3000 && !irq; k++) @(negedge clk);
        chk("irq_done", 32'(irq), 1);
        irq_cyc = cyc;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{addr: src + 32'(4 * i), we: 1'b0, wdata: 32'h0});
            if (i == erd) break;
            exp_q.push_back('{addr: dst + 32'(4 * i), we: 1'b1, wdata: mem_word(src + 32'(4 * i))});
        end
        chk("n_txn", 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("txn_addr", log_q[i].addr, exp_q[i].addr);
            chk("txn_we", 32'(log_q[i].we), 32'(exp_q[i].we));
            chk("txn_wdata", log_q[i].wdata, exp_q[i].wdata);
        end
    endtask

    initial begin : main
        logic [31:0] d, src, dst;
        int len;
        sreq = '0;
        repeat (3) @(negedge clk);
        chk("rst_mreq", 32'(mreq.req), 0);
        chk("rst_maddr", mreq.a.addr, 0);
        chk("rst_rvalid", 32'(srsp.rvalid), 0);
        chk("rst_gnt", 32'(srsp.gnt), 0);
        chk("rst_irq", 32'(irq), 0);
        rst_ni = 1'b1;
        reg_read(32'hC, d); chk("rst_status", d, 0);
        reg_read(32'h0, d); chk("rst_src", d, 0);

        // Zero-wait directed copy
        start_copy(32'h1000_0000, 32'h1000_0100, 3, 0, -1);
        finish_copy(32'h1000_0000, 32'h1000_0100, 3, -1);
        chk("irq_latency", 32'(irq_cyc - first_req_cyc), 12);
        reg_read(32'hC, d); chk("status_ok", d, 32'hA);
        reg_read(32'h8, d); chk("len_rd", d, 3);

        // Random grant latency, random aligned addresses and lengths
        for (int t = 0; t < 4; t++) begin
            src = {$urandom} & 32'hFFFF_FFFC;
            dst = {$urandom} & 32'hFFFF_FFFC;
            len = (t == 0) ? 3 : $urandom_range(6, 1);
            if (t == 0) begin src = 32'h1000_0000; dst = 32'h1000_0100; end
            start_copy(src | 32'h3, dst | 32'h1, len, 5, -1);
            finish_copy(src, dst, len, -1);
            reg_read(32'h0, d); chk("src_masked", d, src);
        end

        // LEN = 0: done one cycle after start grant, no bus traffic
        start_copy(32'h2000_0000, 32'h2000_1000, 0, 0, -1);
        chk("len0_irq", 32'(irq), 1);
        repeat (5) @(negedge clk);
        chk("len0_ntxn", 32'(log_q.size()), 0);
        reg_read(32'hC, d); chk("len0_status", d, 32'hA);

        // Error on the second read
        start_copy(32'h2000_0000, 32'h3000_0000, 4, 2, 1);
        finish_copy(32'h2000_0000, 32'h3000_0000, 4, 1);
        reg_read(32'hC, d); chk("err_status", d, 32'hE);
        reg_write(32'hC, 32'h4);
        chk("clr_irq", 32'(irq), 0);
        reg_read(32'hC, d); chk("clr_status", d, 0);

        // Writes and start while busy
        start_copy(32'h4000_0000, 32'h5000_0000, 6, 3, -1);
        reg_write(32'h0, 32'h7777_0000);
        reg_write(32'h8, 32'h1);
        reg_write(32'hC, 32'h1);
        reg_read(32'hC, d); chk("busy_status", d, 32'h1);
        reg_write(32'hC, 32'h2);
        reg_read(32'h0, d); chk("busy_src", d, 32'h4000_0000);
        finish_copy(32'h4000_0000, 32'h5000_0000, 6, -1);
        reg_read(32'h8, d); chk("busy_len", d, 6);
        reg_read(32'hC, d); chk("busy_done", d, 32'hA);

        // Address wrap, then reset in the middle of the copy
        start_copy(32'hFFFF_FFFC, 32'h6000_0000, 2, 0, -1);
        for (int k = 0; k < 200 && log_q.size() < 3; k++) @(negedge clk);
        chk("wrap_ntxn", 32'(log_q.size() >= 3), 1);
        if (log_q.size() >= 3) begin
            chk("wrap_rd0", log_q[0].addr, 32'hFFFF_FFFC);
            chk("wrap_rd1", log_q[2].addr, 32'h0000_0000);
            chk("wrap_wdata", log_q[1].wdata, mem_word(32'hFFFF_FFFC));
        end
        @(negedge clk);
        for (int k = 0; k < 200 && !mreq.req; k++) @(negedge clk);
        chk("pre_rst_req", 32'(mreq.req), 1);
        #2 rst_ni = 1'b0;
        #1 chk("rst_req_drop", 32'(mreq.req), 0);
        chk("rst_irq_drop", 32'(irq), 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        reg_read(32'hC, d); chk("post_rst_status", d, 0);
        chk("post_rst_req", 32'(mreq.req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
